// File: rtl/vote_recorder.sv
// vote_recorder: synchronised, debounced four-candidate vote capture with saturating tallies.
// Optional VOTE_TOTAL_EN adds a registered total_votes output.
module vote_recorder #(
    parameter int COUNT_W         = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LOCKOUT_CYCLES  = 100_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mode,
    input  logic               cand1_btn,
    input  logic               cand2_btn,
    input  logic               cand3_btn,
    input  logic               cand4_btn,
    output logic [COUNT_W-1:0] cand1_vote,
    output logic [COUNT_W-1:0] cand2_vote,
    output logic [COUNT_W-1:0] cand3_vote,
    output logic [COUNT_W-1:0] cand4_vote,
    output logic               valid_vote_casted,
    output logic               busy
`ifdef VOTE_TOTAL_EN
    ,
    output logic [COUNT_W+1:0] total_votes
`endif
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] TALLY_MAX = '1;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, CAST, LOCKOUT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         sync1_q, sync2_q, sel_q, sel_d, s_btn;
    logic [DW-1:0]      deb_q, deb_d;
    logic [LW-1:0]      lock_q, lock_d;
    logic [COUNT_W-1:0] tally_q [4];
    logic [COUNT_W-1:0] tally_d [4];
    logic               valid_q, valid_d;
`ifdef VOTE_TOTAL_EN
    logic [COUNT_W+1:0] total_q, total_d;
    assign total_votes = total_q;
`endif

    assign s_btn             = sync2_q;
    assign cand1_vote        = tally_q[0];
    assign cand2_vote        = tally_q[1];
    assign cand3_vote        = tally_q[2];
    assign cand4_vote        = tally_q[3];
    assign valid_vote_casted = valid_q;
    assign busy              = (state_q != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            sel_q   <= '0;
            deb_q   <= '0;
            lock_q  <= '0;
            tally_q <= '{default: '0};
            valid_q <= 1'b0;
`ifdef VOTE_TOTAL_EN
            total_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= {cand4_btn, cand3_btn, cand2_btn, cand1_btn};
            sync2_q <= sync1_q;
            sel_q   <= sel_d;
            deb_q   <= deb_d;
            lock_q  <= lock_d;
            tally_q <= tally_d;
            valid_q <= valid_d;
`ifdef VOTE_TOTAL_EN
            total_q <= total_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        deb_d   = deb_q;
        lock_d  = lock_q;
        tally_d = tally_q;
        valid_d = 1'b0;
`ifdef VOTE_TOTAL_EN
        total_d = total_q;
`endif
        case (state_q)
            IDLE: begin
                if (!mode && $onehot(s_btn)) begin
                    state_d = DEBOUNCE;
                    sel_d   = s_btn;
                    deb_d   = DW'(1);
                end
            end
            DEBOUNCE: begin
                if (mode || s_btn != sel_q) state_d = IDLE;
                else if (deb_q == DEB_LAST) state_d = CAST;
                else deb_d = deb_q + DW'(1);
            end
            CAST: begin
                state_d = LOCKOUT;
                lock_d  = '0;
                valid_d = 1'b1;
                // saturated tallies still acknowledge the voter via valid
                for (int i = 0; i < 4; i++) begin
                    if (sel_q[i] && tally_q[i] != TALLY_MAX) begin
                        tally_d[i] = tally_q[i] + COUNT_W'(1);
`ifdef VOTE_TOTAL_EN
                        total_d = total_q + (COUNT_W + 2)'(1);
`endif
                    end
                end
            end
            LOCKOUT: begin
                lock_d = (lock_q >= LOCK_LAST) ? lock_q : lock_q + LW'(1);
                if (lock_q >= LOCK_LAST && s_btn == '0) state_d = IDLE;
            end
        endcase
    end
endmodule
